// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a TDM mux link. Locks onto frame_sync, collects
// one sample per channel in a shadow buffer and publishes each complete frame
// atomically on y with a one-cycle frame_valid strobe.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din         incoming sample (WIDTH bits)
//   din_valid   qualifies din and frame_sync
//   frame_sync  marks the beat as slot 0
//   y           last complete frame, channel k at y[k*WIDTH +: WIDTH]
//   frame_valid one-cycle pulse when y is updated
//   slot        slot index the next valid beat will be written to
//   locked      high while frame-locked
//   frame_err   one-cycle pulse on early or missing sync
//               (port present only when TDM_DEMUX_ERR_EN is defined)
//
// Build option: define TDM_DEMUX_ERR_EN to enable sync-error detection.
// Without it, a missing sync at slot 0 is taken as slot 0 (free-running)
// and an early sync restarts the frame silently.

module tdm_demux #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SW    = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [N_CH*WIDTH-1:0] y,
    output logic                  frame_valid,
    output logic [SW-1:0]         slot,
`ifdef TDM_DEMUX_ERR_EN
    output logic                  frame_err,
`endif
    output logic                  locked
);

    localparam int unsigned YW   = N_CH * WIDTH;
    localparam int unsigned LAST = N_CH - 1;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [SW-1:0]                slot_q, slot_d;
    // Only slots 0..N_CH-2 are buffered; the top channel goes straight to y.
    logic [LAST-1:0][WIDTH-1:0]   shadow_q, shadow_d;
    logic [YW-1:0]                y_q, y_d;
    logic                         fv_q, fv_d;
`ifdef TDM_DEMUX_ERR_EN
    logic                         err_q, err_d;
`endif

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            slot_q   <= '0;
            shadow_q <= '0;
            y_q      <= '0;
            fv_q     <= 1'b0;
`ifdef TDM_DEMUX_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            y_q      <= y_d;
            fv_q     <= fv_d;
`ifdef TDM_DEMUX_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    // Next-state, slot tracking and frame assembly
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        y_d      = y_q;
        fv_d     = 1'b0;
`ifdef TDM_DEMUX_ERR_EN
        err_d    = 1'b0;
`endif
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        slot_d      = SW'(1);
                        state_d     = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (frame_sync) begin
                        // Normal start, or early sync dropping a partial frame
                        shadow_d[0] = din;
                        slot_d      = SW'(1);
`ifdef TDM_DEMUX_ERR_EN
                        err_d       = (slot_q != '0);
`endif
                    end else if ((slot_q == '0) || (slot_q > SW'(LAST))) begin
                        // Missing sync; out-of-range slot is handled the same way
`ifdef TDM_DEMUX_ERR_EN
                        state_d = ST_HUNT;
                        slot_d  = '0;
                        err_d   = 1'b1;
`else
                        shadow_d[0] = din;
                        slot_d      = SW'(1);
`endif
                    end else if (slot_q == SW'(LAST)) begin
                        // Last slot: publish the whole frame at once
                        for (int unsigned k = 0; k < LAST; k++) begin
                            y_d[k*WIDTH +: WIDTH] = shadow_q[k];
                        end
                        y_d[LAST*WIDTH +: WIDTH] = din;
                        fv_d   = 1'b1;
                        slot_d = '0;
                    end else begin
                        for (int unsigned k = 1; k < LAST; k++) begin
                            if (slot_q == SW'(k)) begin
                                shadow_d[k] = din;
                            end
                        end
                        slot_d = slot_q + SW'(1);
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    assign y           = y_q;
    assign frame_valid = fv_q;
    assign slot        = slot_q;
    assign locked      = (state_q == ST_LOCKED);
`ifdef TDM_DEMUX_ERR_EN
    assign frame_err   = err_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a 2-channel and a 3-channel instance share
// clock and reset; expectations are hand-computed per step.

module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [3:0]  da = '0;
    logic        va = 1'b0;
    logic        sa = 1'b0;
    logic [7:0]  ya;
    logic        fva;
    logic [0:0]  slota;
    logic        lka;

    logic [3:0]  db = '0;
    logic        vb = 1'b0;
    logic        sb = 1'b0;
    logic [11:0] yb;
    logic        fvb;
    logic [1:0]  slotb;
    logic        lkb;

    int n_cmp = 0;
    int n_bad = 0;
    int fva_cnt = 0;
    int fvb_cnt = 0;
    int mark;
`ifdef TDM_DEMUX_ERR_EN
    logic        erra;
    logic        errb;
    int erra_cnt = 0;
    int errb_cnt = 0;
`endif

    always #5 clk = ~clk;

    tdm_demux #(.N_CH(2), .WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .din(da), .din_valid(va), .frame_sync(sa),
        .y(ya), .frame_valid(fva), .slot(slota),
`ifdef TDM_DEMUX_ERR_EN
        .frame_err(erra),
`endif
        .locked(lka)
    );

    tdm_demux #(.N_CH(3), .WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .din(db), .din_valid(vb), .frame_sync(sb),
        .y(yb), .frame_valid(fvb), .slot(slotb),
`ifdef TDM_DEMUX_ERR_EN
        .frame_err(errb),
`endif
        .locked(lkb)
    );

    // Pulse counters: each one-cycle pulse spans exactly one falling edge
    always @(negedge clk) begin
        if (fva) fva_cnt++;
        if (fvb) fvb_cnt++;
`ifdef TDM_DEMUX_ERR_EN
        if (erra) erra_cnt++;
        if (errb) errb_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat_a(input logic s, input logic [3:0] d);
        @(negedge clk);
        va = 1'b1; sa = s; da = d;
        @(posedge clk); #1;
        va = 1'b0; sa = 1'b0;
    endtask

    task automatic beat_b(input logic s, input logic [3:0] d);
        @(negedge clk);
        vb = 1'b1; sb = s; db = d;
        @(posedge clk); #1;
        vb = 1'b0; sb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_y", 32'(ya), 32'h00);
        chk("rst_fv", 32'(fva), 32'd0);
        chk("rst_slot", 32'(slota), 32'd0);
        chk("rst_locked", 32'(lka), 32'd0);
`ifdef TDM_DEMUX_ERR_EN
        chk("rst_err", 32'(erra), 32'd0);
`endif

        // 1: basic frame
        beat_a(1'b1, 4'h3);
        chk("t1_locked_after_sync", 32'(lka), 32'd1);
        chk("t1_slot_after_sync", 32'(slota), 32'd1);
        chk("t1_fv_after_sync", 32'(fva), 32'd0);
        beat_a(1'b0, 4'h5);
        chk("t1_fv", 32'(fva), 32'd1);
        chk("t1_y", 32'(ya), 32'h53);
        chk("t1_slot", 32'(slota), 32'd0);
        chk("t1_locked", 32'(lka), 32'd1);
        idle(1);
        chk("t1_fv_drop", 32'(fva), 32'd0);
        chk("t1_y_hold", 32'(ya), 32'h53);

        // 2: beats before any sync are discarded
        do_reset();
        mark = fva_cnt;
        beat_a(1'b0, 4'h7);
        chk("t2_locked0", 32'(lka), 32'd0);
        beat_a(1'b0, 4'h2);
        chk("t2_locked1", 32'(lka), 32'd0);
        chk("t2_slot", 32'(slota), 32'd0);
        chk("t2_y", 32'(ya), 32'h00);
        idle(1);
        chk("t2_no_fv", 32'(fva_cnt - mark), 32'd0);
        beat_a(1'b1, 4'h1);
        beat_a(1'b0, 4'h4);
        chk("t2_y_lock", 32'(ya), 32'h41);
        chk("t2_fv", 32'(fva), 32'd1);

        // 3: hold across idle, gaps within a frame
        idle(1);
        mark = fva_cnt;
        beat_a(1'b1, 4'h1);
        beat_a(1'b0, 4'h2);
        chk("t3_y_first", 32'(ya), 32'h21);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t3_y_idle", 32'(ya), 32'h21);
            chk("t3_fv_idle", 32'(fva), 32'd0);
        end
        beat_a(1'b1, 4'h9);
        idle(2);
        chk("t3_y_gap", 32'(ya), 32'h21);
        chk("t3_slot_gap", 32'(slota), 32'd1);
        beat_a(1'b0, 4'hA);
        chk("t3_y_second", 32'(ya), 32'hA9);
        idle(1);
        chk("t3_fv_count", 32'(fva_cnt - mark), 32'd2);

        // 5: missing sync at slot 0
`ifdef TDM_DEMUX_ERR_EN
        mark = erra_cnt;
        beat_a(1'b0, 4'hF);
        chk("t5_err", 32'(erra), 32'd1);
        chk("t5_locked", 32'(lka), 32'd0);
        chk("t5_slot", 32'(slota), 32'd0);
        chk("t5_y_hold", 32'(ya), 32'hA9);
        beat_a(1'b0, 4'hE);
        chk("t5_err_drop", 32'(erra), 32'd0);
        chk("t5_y_hunt", 32'(ya), 32'hA9);
        idle(1);
        chk("t5_err_count", 32'(erra_cnt - mark), 32'd1);
`else
        beat_a(1'b0, 4'hF);
        chk("t5_locked_free", 32'(lka), 32'd1);
        chk("t5_slot_free", 32'(slota), 32'd1);
        beat_a(1'b0, 4'hE);
        chk("t5_y_free", 32'(ya), 32'hEF);
        chk("t5_fv_free", 32'(fva), 32'd1);
        chk("t5_locked_after", 32'(lka), 32'd1);
`endif

        // 6: reset mid-frame, with a concurrent beat
        do_reset();
        beat_a(1'b1, 4'h3);
        beat_a(1'b0, 4'h5);
        chk("t6_y_pre", 32'(ya), 32'h53);
        beat_a(1'b1, 4'h3);
        chk("t6_slot_pre", 32'(slota), 32'd1);
        @(negedge clk);
        rst = 1'b1; va = 1'b1; sa = 1'b0; da = 4'h5;
        @(posedge clk); #1;
        va = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_y", 32'(ya), 32'h00);
        chk("t6_slot", 32'(slota), 32'd0);
        chk("t6_locked", 32'(lka), 32'd0);
        chk("t6_fv", 32'(fva), 32'd0);
        beat_a(1'b0, 4'h5);
        chk("t6_discard_locked", 32'(lka), 32'd0);
        chk("t6_discard_slot", 32'(slota), 32'd0);
        chk("t6_discard_y", 32'(ya), 32'h00);

        // 4: early sync with three channels, then back-to-back sync
        mark = fvb_cnt;
        beat_b(1'b1, 4'h1);
        beat_b(1'b0, 4'h2);
        chk("t4_slot2", 32'(slotb), 32'd2);
        beat_b(1'b1, 4'h6);
`ifdef TDM_DEMUX_ERR_EN
        chk("t4_err", 32'(errb), 32'd1);
`endif
        chk("t4_locked", 32'(lkb), 32'd1);
        chk("t4_slot_restart", 32'(slotb), 32'd1);
        chk("t4_fv_none", 32'(fvb), 32'd0);
        chk("t4_y_none", 32'(yb), 32'h000);
        beat_b(1'b0, 4'h7);
`ifdef TDM_DEMUX_ERR_EN
        chk("t4_err_drop", 32'(errb), 32'd0);
`endif
        beat_b(1'b0, 4'h8);
        chk("t4_y", 32'(yb), 32'h876);
        chk("t4_fv", 32'(fvb), 32'd1);
        chk("t4_slot_wrap", 32'(slotb), 32'd0);
        beat_b(1'b1, 4'h3);
`ifdef TDM_DEMUX_ERR_EN
        chk("t4_b2b_no_err", 32'(errb), 32'd0);
`endif
        chk("t4_b2b_slot", 32'(slotb), 32'd1);
        chk("t4_b2b_fv_drop", 32'(fvb), 32'd0);
        idle(1);
        chk("t4_fv_count", 32'(fvb_cnt - mark), 32'd1);
`ifdef TDM_DEMUX_ERR_EN
        chk("t4_err_count", 32'(errb_cnt), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
